mm_ctrl_fsm: RTL and testbench
==============================

MM_CTRL_FSM -- requirements
Module: mm_ctrl_fsm

Interface
REQ-001 SHALL have parameters (name, default, meaning): ROW, 4, array rows; COL, 4, array columns; W_SIZE, 512, weight memory depth; I_SIZE, 512, input memory depth; O_SIZE, 512, output/psum memory depth.
REQ-002 SHALL have ports (name direction width meaning), one clock, async active-low reset:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin job; sampled in IDLE only
- cfg_i  in  data_config_struct  job configuration
- state_o  out  state_struct  current FSM state
- busy_o  out  1  high when state != IDLE
- done_o  out  1  one-cycle pulse in DONE
- w_ren_o / w_addr_o  out  1 / clog2(W_SIZE)  weight memory read
- load_w_o  out  1  array weight push enable
- i_ren_o / i_addr_o  out  1 / clog2(I_SIZE)  input memory read
- psum_ren_o / psum_addr_o  out  1 / clog2(O_SIZE)  psum memory read
- o_wen_o / o_addr_o  out  1 / clog2(O_SIZE)  output memory write
- accum_o  out  1  latched accum_en

Function
REQ-003 SHALL latch cfg_i on the cycle start_i is sampled high in IDLE; cfg_i changes during a job have no effect.
REQ-004 SHALL treat w_rows and i_rows as count-minus-one (NW = w_rows+1, NI = i_rows+1); w_cols is passed through unused.
REQ-005 SHALL go IDLE->LOAD on the cycle after start_i; start_i outside IDLE is ignored.
REQ-006 LOAD SHALL last NW cycles: w_ren_o high, w_addr_o = w_offset+k, k=0..NW-1; load_w_o follows w_ren_o by 1 cycle (1-cycle memory latency).
REQ-007 After LOAD, i_ren_o SHALL be high for NI consecutive cycles, i_addr_o = i_offset+j.
REQ-008 o_wen_o SHALL be high for NI consecutive cycles starting LAT = ROW+COL cycles after the first i_ren_o, o_addr_o = o_offset_w+m.
REQ-009 State SHALL be IN_ONLY while inputs issue and no output written; IN_OUT while both; OUT_ONLY while outputs only; IN_ONLY->OUT_ONLY directly when NI < LAT.
REQ-010 After the last o_wen_o, DONE SHALL hold one cycle (done_o=1), then IDLE.
REQ-011 When accum_o=1, psum_ren_o SHALL assert one cycle before each o_wen_o with psum_addr_o = psum_offset+m; never asserted when accum_o=0.
REQ-012 All address arithmetic SHALL wrap modulo memory depth (field width), no error flag.
REQ-013 Address outputs SHALL hold their last value when the matching strobe is low.

Reset
REQ-014 rst_n low SHALL asynchronously force IDLE, all strobes, busy_o, done_o, accum_o low, all addresses 0, counters 0.
REQ-015 Reset mid-job SHALL abandon the job; no strobe is asserted after reset until a new start_i.

Configuration
REQ-016 With MM_CTRL_PERF_CNT_EN defined, SHALL add output cycle_cnt_o [15:0]: cleared on start, counts every non-IDLE cycle incl. DONE, saturates at 0xFFFF, holds until next start; reset 0.
REQ-017 Without MM_CTRL_PERF_CNT_EN, cycle_cnt_o and its counter SHALL be absent; all else identical.

Verification
REQ-018 w_rows=3, i_rows=9, w_offset=0x010, i_offset=0x020, o_offset_w=0x100, accum_en=0, start at cycle 0 -> LOAD 1-4 (w_addr 0x010-0x013), i_ren 5-14 (0x020-0x029), IN_ONLY 5-12, IN_OUT 13-14, OUT_ONLY 15-22, o_wen 13-22 (0x100-0x109), done_o at 23, IDLE at 24.
REQ-019 Same with i_rows=1 -> i_ren 5-6, OUT_ONLY 7-14, o_wen 13-14, DONE 15; IN_OUT never entered.
REQ-020 accum_en=1, psum_offset=0x080, REQ-018 config -> psum_ren 12-21, psum_addr 0x080-0x089; accum_o=1 whole job.
REQ-021 i_offset=0x1FE, i_rows=3 -> i_addr 0x1FE, 0x1FF, 0x000, 0x001.
REQ-022 rst_n low at cycle 10 of REQ-018, start_i pulse during busy -> immediate IDLE, all strobes 0; start_i during busy ignored.
REQ-023 MM_CTRL_PERF_CNT_EN defined, REQ-018 job -> cycle_cnt_o = 23 after DONE, held through IDLE.

Source files
------------

// File: rtl/mm_ctrl_pkg.sv
// rtl/mm_ctrl_pkg.sv - job configuration and FSM state types for mm_ctrl_fsm
package mm_ctrl_pkg;

  typedef struct packed {
    logic [7:0]  w_rows;
    logic [7:0]  w_cols;
    logic [7:0]  i_rows;
    logic [15:0] w_offset;
    logic [15:0] i_offset;
    logic [15:0] o_offset_w;
    logic [15:0] psum_offset;
    logic        accum_en;
  } data_config_struct;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    IN_ONLY  = 3'd2,
    IN_OUT   = 3'd3,
    OUT_ONLY = 3'd4,
    DONE     = 3'd5
  } state_struct;

endpackage

// File: rtl/mm_ctrl_fsm.sv
// rtl/mm_ctrl_fsm.sv - systolic matmul job sequencer: weight load, input stream, output drain
// Optional cycle counter output enabled by defining MM_CTRL_PERF_CNT_EN.
module mm_ctrl_fsm
  import mm_ctrl_pkg::*;
#(
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = 512,
  parameter int I_SIZE = 512,
  parameter int O_SIZE = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  data_config_struct         cfg_i,
  output state_struct               state_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      w_ren_o,
  output logic [$clog2(W_SIZE)-1:0] w_addr_o,
  output logic                      load_w_o,
  output logic                      i_ren_o,
  output logic [$clog2(I_SIZE)-1:0] i_addr_o,
  output logic                      psum_ren_o,
  output logic [$clog2(O_SIZE)-1:0] psum_addr_o,
  output logic                      o_wen_o,
  output logic [$clog2(O_SIZE)-1:0] o_addr_o,
  output logic                      accum_o
`ifdef MM_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]               cycle_cnt_o
`endif
);

  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int OAW = $clog2(O_SIZE);
  localparam logic [15:0] LAT = 16'(ROW + COL);

  state_struct       state_q, state_d;
  data_config_struct cfg_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_p1, nw, ni, o_idx, p_idx;
  logic              in_phase, w_ren, i_ren, o_wen, psum_ren, load_w_q;
  logic [WAW-1:0]    w_live, w_hold;
  logic [IAW-1:0]    i_live, i_hold;
  logic [OAW-1:0]    o_live, o_hold, p_live, p_hold;
  logic              unused_cfg;

  assign unused_cfg = ^{cfg_q.w_cols, cfg_q.w_offset, cfg_q.i_offset,
                        cfg_q.o_offset_w, cfg_q.psum_offset};

  assign nw       = {8'd0, cfg_q.w_rows} + 16'd1;
  assign ni       = {8'd0, cfg_q.i_rows} + 16'd1;
  assign cnt_p1   = cnt_q + 16'd1;
  assign o_idx    = cnt_q - LAT;
  assign p_idx    = cnt_p1 - LAT;
  assign in_phase = (state_q == IN_ONLY) || (state_q == IN_OUT) || (state_q == OUT_ONLY);

  // One counter serves both phases: weight index in LOAD, cycles since first input afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == nw - 16'd1) begin
          state_d = IN_ONLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_p1;
        end
      end
      IN_ONLY, IN_OUT, OUT_ONLY: begin
        cnt_d = cnt_p1;
        if (cnt_p1 < ni)
          state_d = (cnt_p1 >= LAT) ? IN_OUT : IN_ONLY;
        else if (cnt_p1 >= LAT + ni)
          state_d = DONE;
        else
          state_d = OUT_ONLY;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_ren    = (state_q == LOAD);
  assign i_ren    = in_phase && (cnt_q < ni);
  assign o_wen    = in_phase && (cnt_q >= LAT) && (cnt_q < LAT + ni);
  assign psum_ren = cfg_q.accum_en && in_phase && (cnt_p1 >= LAT) && (cnt_p1 < LAT + ni);

  assign w_live = cfg_q.w_offset[WAW-1:0] + cnt_q[WAW-1:0];
  assign i_live = cfg_q.i_offset[IAW-1:0] + cnt_q[IAW-1:0];
  assign o_live = cfg_q.o_offset_w[OAW-1:0] + o_idx[OAW-1:0];
  assign p_live = cfg_q.psum_offset[OAW-1:0] + p_idx[OAW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      load_w_q <= 1'b0;
      w_hold   <= '0;
      i_hold   <= '0;
      o_hold   <= '0;
      p_hold   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_w_q <= w_ren;
      if (state_q == IDLE && start_i) cfg_q <= cfg_i;
      if (w_ren)    w_hold <= w_live;
      if (i_ren)    i_hold <= i_live;
      if (o_wen)    o_hold <= o_live;
      if (psum_ren) p_hold <= p_live;
    end
  end

  // Addresses follow the live value while strobed and otherwise show the last issued one.
  assign w_addr_o    = w_ren    ? w_live : w_hold;
  assign i_addr_o    = i_ren    ? i_live : i_hold;
  assign o_addr_o    = o_wen    ? o_live : o_hold;
  assign psum_addr_o = psum_ren ? p_live : p_hold;

  assign state_o    = state_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign w_ren_o    = w_ren;
  assign load_w_o   = load_w_q;
  assign i_ren_o    = i_ren;
  assign o_wen_o    = o_wen;
  assign psum_ren_o = psum_ren;
  assign accum_o    = cfg_q.accum_en;

`ifdef MM_CTRL_PERF_CNT_EN
  logic [15:0] cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_q <= '0;
    else if (state_q == IDLE && start_i)
      cycle_q <= '0;
    else if (state_q != IDLE && cycle_q != 16'hFFFF)
      cycle_q <= cycle_q + 16'd1;
  end

  assign cycle_cnt_o = cycle_q;
`endif

endmodule

// File: tb/tb_mm_ctrl_fsm.sv
// tb/tb_mm_ctrl_fsm.sv - directed self-checking bench for mm_ctrl_fsm
module tb_mm_ctrl_fsm;
  import mm_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  data_config_struct cfg_i = '0;
  state_struct       state_o;
  logic              busy_o, done_o, w_ren_o, load_w_o, i_ren_o, psum_ren_o, o_wen_o, accum_o;
  logic [8:0]        w_addr_o, i_addr_o, psum_addr_o, o_addr_o;
`ifdef MM_CTRL_PERF_CNT_EN
  logic [15:0]       cycle_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  mm_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_i(cfg_i),
    .state_o(state_o), .busy_o(busy_o), .done_o(done_o),
    .w_ren_o(w_ren_o), .w_addr_o(w_addr_o), .load_w_o(load_w_o),
    .i_ren_o(i_ren_o), .i_addr_o(i_addr_o),
    .psum_ren_o(psum_ren_o), .psum_addr_o(psum_addr_o),
    .o_wen_o(o_wen_o), .o_addr_o(o_addr_o), .accum_o(accum_o)
`ifdef MM_CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " state"}, 32'(state_o), 32'(IDLE));
    chk({tag, " busy"}, 32'(busy_o), 0);
    chk({tag, " done"}, 32'(done_o), 0);
    chk({tag, " strobes"}, {27'd0, w_ren_o, load_w_o, i_ren_o, psum_ren_o, o_wen_o}, 0);
  endtask

  // Job timeline: cycle 0 carries start_i; ranges are hand-derived with LAT = 8.
  task automatic run_job(input string name, input data_config_struct c, input int lw_end,
                         input int ie, input int os, input int done_c, input int ps);
    int is_c, oe, pe, ncyc;
    logic ew, el, ei, eo, ep;
    logic [8:0] ea;
    state_struct es;
    is_c = lw_end + 1;
    oe   = os + (ie - is_c);
    pe   = ps + (ie - is_c);
    ncyc = done_c + 3;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      start_i = (cyc == 0 || cyc == 3);
      if (cyc == 0) cfg_i = c;
      if (cyc == 1) begin
        cfg_i.w_rows     = 8'h20;
        cfg_i.i_rows     = 8'h30;
        cfg_i.w_offset   = 16'h0055;
        cfg_i.i_offset   = 16'h0066;
        cfg_i.o_offset_w = 16'h0077;
        cfg_i.accum_en   = ~c.accum_en;
      end
      ew = (cyc >= 1 && cyc <= lw_end);
      el = (cyc >= 2 && cyc <= lw_end + 1);
      ei = (cyc >= is_c && cyc <= ie);
      eo = (cyc >= os && cyc <= oe);
      ep = (ps >= 0 && cyc >= ps && cyc <= pe);
      if (cyc == 0 || cyc > done_c) es = IDLE;
      else if (cyc <= lw_end)       es = LOAD;
      else if (cyc == done_c)       es = DONE;
      else if (ei && eo)            es = IN_OUT;
      else if (ei)                  es = IN_ONLY;
      else                          es = OUT_ONLY;
      chk({name, " state"}, 32'(state_o), 32'(es));
      chk({name, " w_ren"}, 32'(w_ren_o), 32'(ew));
      chk({name, " load_w"}, 32'(load_w_o), 32'(el));
      chk({name, " i_ren"}, 32'(i_ren_o), 32'(ei));
      chk({name, " o_wen"}, 32'(o_wen_o), 32'(eo));
      chk({name, " psum_ren"}, 32'(psum_ren_o), 32'(ep));
      chk({name, " done"}, 32'(done_o), 32'(cyc == done_c));
      chk({name, " busy"}, 32'(busy_o), 32'(cyc >= 1 && cyc <= done_c));
      if (cyc >= 1) chk({name, " accum"}, 32'(accum_o), 32'(c.accum_en));
      if (cyc >= 1) begin
        ea = c.w_offset[8:0] + 9'((cyc > lw_end ? lw_end : cyc) - 1);
        chk({name, " w_addr"}, 32'(w_addr_o), 32'(ea));
      end
      if (cyc >= is_c) begin
        ea = c.i_offset[8:0] + 9'((cyc > ie ? ie : cyc) - is_c);
        chk({name, " i_addr"}, 32'(i_addr_o), 32'(ea));
      end
      if (cyc >= os) begin
        ea = c.o_offset_w[8:0] + 9'((cyc > oe ? oe : cyc) - os);
        chk({name, " o_addr"}, 32'(o_addr_o), 32'(ea));
      end
      if (ps >= 0 && cyc >= ps) begin
        ea = c.psum_offset[8:0] + 9'((cyc > pe ? pe : cyc) - ps);
        chk({name, " psum_addr"}, 32'(psum_addr_o), 32'(ea));
      end
`ifdef MM_CTRL_PERF_CNT_EN
      if (cyc > done_c) chk({name, " cycle_cnt"}, 32'(cycle_cnt_o), 32'(done_c));
`endif
    end
  endtask

  data_config_struct base;

  initial begin
    base = '0;
    base.w_rows     = 8'd3;
    base.w_cols     = 8'd3;
    base.i_rows     = 8'd9;
    base.w_offset   = 16'h010;
    base.i_offset   = 16'h020;
    base.o_offset_w = 16'h100;
    base.psum_offset = 16'h080;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset addrs", {w_addr_o, i_addr_o, o_addr_o, psum_addr_o[4:0]}, 0);
    chk("reset psum_addr", 32'(psum_addr_o), 0);
    chk("reset accum", 32'(accum_o), 0);
`ifdef MM_CTRL_PERF_CNT_EN
    chk("reset cycle_cnt", 32'(cycle_cnt_o), 0);
`endif
    rst_n = 1'b1;

    run_job("basic", base, 4, 14, 13, 23, -1);

    base.i_rows = 8'd1;
    run_job("short", base, 4, 6, 13, 15, -1);

    base.i_rows   = 8'd9;
    base.accum_en = 1'b1;
    run_job("accum", base, 4, 14, 13, 23, 12);

    base.accum_en   = 1'b0;
    base.i_rows     = 8'd3;
    base.i_offset   = 16'h1FE;
    base.o_offset_w = 16'h1FE;
    run_job("wrap", base, 4, 8, 13, 17, -1);

    base.i_rows     = 8'd9;
    base.i_offset   = 16'h020;
    base.o_offset_w = 16'h100;
    base.accum_en   = 1'b1;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      start_i = (cyc == 0 || cyc == 3);
      if (cyc == 0) cfg_i = base;
    end
    chk("midjob state", 32'(state_o), 32'(IN_ONLY));
    chk("midjob i_ren", 32'(i_ren_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("async reset");
    chk("async reset addrs", {w_addr_o, i_addr_o, o_addr_o, psum_addr_o[4:0]}, 0);
    chk("async reset accum", 32'(accum_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      chk_quiet("post reset");
    end

    base.accum_en = 1'b0;
    run_job("recover", base, 4, 14, 13, 23, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
